adc_spi_responder: RTL and testbench
====================================

# adc_spi_responder

Synthesizable SPI responder that plays the ADC side of the multi-lane conversion/register protocol driven by `adc_manager`. It oversamples the controller's `spi_csn`/`spi_sck`/`spi_sdo`, shifts 32-bit conversion words out on `NUM_SDI` lanes, and decodes 24-bit register frames with the same mode rules as the controller. It sits in loopback test designs and simulation benches in place of the physical ADC.

## Interface
- `NUM_SDI`, 4: number of data lanes. Must divide 32.
- `REG_COUNT`, 16: number of 8-bit registers implemented, at addresses `0..REG_COUNT-1`.

Ports:
- `aclk`  in  1  oversampling clock; the only clock.
- `areset`  in  1  synchronous, active-high reset.
- `spi_csn`  in  1  chip select from the controller, active low.
- `spi_sck`  in  1  SPI clock from the controller.
- `spi_sdo`  in  1  controller-to-ADC serial data.
- `spi_sdi`  out  `NUM_SDI`  ADC-to-controller lanes.
- `s_axis_tdata`  in  32  next conversion sample.
- `s_axis_tvalid`  in  1  sample valid.
- `s_axis_tready`  out  1  high while the sample holding register is empty.
- `reg_wr`  out  1  one-cycle pulse when a register write is committed.
- `reg_addr`  out  15  address of the last committed write.
- `reg_wdata`  out  8  data of the last committed write.
- `status`  out  32  `[1:0]` mode, `[2]` frame active, `[3]` sample held, `[15:8]` underflow count (saturating), `[31:16]` 0.

## Operation
- **Modes** (2 bits): `CNV` = 00 and `REG` = 11. Reset value is `CNV`.
- **Input conditioning.** `spi_csn`, `spi_sck` and `spi_sdo` each pass through a 2-flop synchronizer. Edges are detected on the synchronized `spi_csn` and `spi_sck`. `spi_sdo` is sampled at each detected SCK rising edge.
- **Frame start** (detected CSn fall):
  - Clear the SCK rising-edge counter `nedge` and the receive shift register.
  - In `CNV`:
    - If a sample is held, load it into the TX shift register and clear the held flag.
    - Otherwise load the pattern counter, increment it (wrapping at 32 bits), and increment the underflow count (saturating at 255).
    - Drive `spi_sdi` = TX word bits `[31 -: NUM_SDI]` immediately.
  - In `REG`: drive `spi_sdi` = 0.
- **Detected SCK rise:**
  - `rx <= {rx[22:0], sdo}` while `nedge < 24`.
  - Increment `nedge`, saturating at 63.
- **Detected SCK fall:**
  - In `CNV`: shift TX left by `NUM_SDI` and drive the next chunk. Once `32/NUM_SDI` chunks are exhausted, drive 0.
  - In `REG`: lanes are 0, except during a read frame (see below).
- **Read frame** (`REG` mode, `rx[15]==1` after the 16th rise): after SCK falls 16 through 23, `spi_sdi[0]` drives register `addr[7:0]`, MSB first.
  - An out-of-range address reads 0.
  - All other lanes stay 0.
- **Frame end** (detected CSn rise): set `spi_sdi` = 0. The frame is processed only if `nedge == 24` exactly; all other counts are discarded. Let `f = rx[23:0]`. Rules apply in order:
  1. If `f[23:21] == 3'b101`: mode becomes `REG`; no write.
  2. Else if `f == 24'h001401` (exit): write register 0x14 = 0x01 when in range, then mode becomes `CNV`.
  3. Else if `f[23] == 0`: write `f[7:0]` to address `f[22:8]`. Pulse `reg_wr` even when the address is out of range, but do not store the data in that case. The mode is unchanged.
  4. A valid 24-edge frame in `CNV` is a one-shot register access; the mode stays `CNV`.
- **Sample input.** `s_axis_tready` = ~held flag (combinational). A handshake stores `tdata` and sets the held flag.
  - If a handshake coincides with a frame start, the frame start sees the pre-handshake flag. When the flag was clear, the pattern is used and the new sample is kept for the next frame.

## Timing
- Pin-to-action latency: 3 `aclk` cycles (2 synchronizer stages plus the edge register). Lane outputs are registered, so a lane changes 4 cycles after the causing pin edge.
- Required relationships, in `aclk` cycles:
  - SCK high time ≥ 4.
  - SCK low time ≥ 4.
  - CSn fall to first SCK rise ≥ 5.
  - CSn high time ≥ 4.
- This implies a controller clock of at most `aclk`/8.
- `reg_wr` asserts 1 cycle after the CSn-rise detection. `reg_addr`/`reg_wdata` update in that same cycle and hold until the next write.
- Reset values:
  - `spi_sdi` = 0, `reg_wr` = 0, `reg_addr` = 0, `reg_wdata` = 0.
  - Mode `CNV`; pattern counter, underflow count and registers all 0.
  - Held flag = 0, so `s_axis_tready` = 1 while `areset` is high.
- Reset mid-frame aborts the frame with no write. After release, the block waits for a fresh CSn fall; a CSn that is already low is ignored until it rises and falls again.
- CSn rising mid-frame aborts and discards the frame as described under Frame end.

## Structure
- Package `adc_pkg`:
  - mode encodings `CNV`/`REG`;
  - `ADC_EXIT_FRAME` = 24'h001401;
  - `ADC_ENTER_PREFIX` = 3'b101;
  - `ADC_REG_FRAME_BITS` = 24;
  - `ADC_CNV_BITS` = 32.
- `adc_manager` reuses the same package.
- Sub-module `adc_spi_edge_sync`: 2-flop synchronizer plus rise/fall pulse outputs. It is instantiated for CSn and SCK; the SDO path uses only its synchronizer.

## Test plan
- Sample 0x12345678 queued, `NUM_SDI`=4, 8-SCK frame -> controller captures 0x12345678, lane nibbles 1,2,…,8; `s_axis_tready` returns to 1.
- Two frames with no sample queued -> words 0x00000000 then 0x00000001; `status[15:8]` = 2.
- Frame 0xBFFF00 -> `status[1:0]` = 11. Then 0x000A5C -> `reg_wr` pulse, addr 0x000A, data 0x5C. Then 0x001401 -> mode 00.
- In `REG`, read frame 0x800A00 -> `spi_sdi[0]` shifts 0x5C over clocks 17–24.
- In `CNV`, a 24-edge frame 0x000342 -> register 3 = 0x42 and mode stays 00. A 10-edge `REG` frame -> no `reg_wr`.
- `areset` asserted after 5 SCK edges of a frame -> all outputs at reset values; the next full frame behaves normally.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared encodings for the multi-lane ADC SPI protocol, used by both the
// controller (adc_manager) and the responder.
package adc_pkg;

    typedef enum logic [1:0] {
        CNV = 2'b00,
        REG = 2'b11
    } adc_mode_e;

    localparam logic [23:0] ADC_EXIT_FRAME     = 24'h001401;
    localparam logic [2:0]  ADC_ENTER_PREFIX   = 3'b101;
    localparam int          ADC_REG_FRAME_BITS = 24;
    localparam int          ADC_CNV_BITS       = 32;

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI pins between the ADC controller (master) and the ADC or its responder model (slave).
interface adc_spi_responder_if #(
    parameter int NUM_SDI = 4
);
    logic               spi_csn;
    logic               spi_sck;
    logic               spi_sdo;
    logic [NUM_SDI-1:0] spi_sdi;

    modport master (output spi_csn, spi_sck, spi_sdo, input  spi_sdi);
    modport slave  (input  spi_csn, spi_sck, spi_sdo, output spi_sdi);
endinterface

// File: rtl/adc_spi_edge_sync.sv
// Two-flop synchronizer for one asynchronous pin, with registered one-cycle
// rise/fall pulses derived from the synchronized level.
module adc_spi_edge_sync (
    input  logic aclk,
    input  logic areset,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);
    logic s1, s2, prev;

    // NOTE: all state here uses <= so every flop samples pre-edge values;
    // blocking assignments would collapse the chain into a single stage.
    always_ff @(posedge aclk) begin
        if (areset) begin
            // Preloading with the live pin level means a level held through
            // reset is never mistaken for an edge after release.
            s1   <= din;
            s2   <= din;
            prev <= din;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
            rise <= s2 & ~prev;
            fall <= ~s2 & prev;
        end
    end

    assign q = s2;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC-side SPI responder: streams 32-bit conversion words on NUM_SDI lanes and
// decodes 24-bit register frames using the controller's mode rules.
module adc_spi_responder
    import adc_pkg::*;
#(
    parameter int NUM_SDI   = 4,
    parameter int REG_COUNT = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    adc_spi_responder_if.slave      spi,
    input  logic [31:0]             s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic                    reg_wr,
    output logic [14:0]             reg_addr,
    output logic [7:0]              reg_wdata,
    output logic [31:0]             status
);
    localparam int          AW          = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [5:0]  FRAME_EDGES = 6'(ADC_REG_FRAME_BITS);
    localparam logic [14:0] REG_LIMIT   = 15'(REG_COUNT);

    logic csn_rise, csn_fall, sck_rise, sck_fall, sdo;

    adc_spi_edge_sync u_csn (.aclk(aclk), .areset(areset), .din(spi.spi_csn),
                             .q(), .rise(csn_rise), .fall(csn_fall));
    adc_spi_edge_sync u_sck (.aclk(aclk), .areset(areset), .din(spi.spi_sck),
                             .q(), .rise(sck_rise), .fall(sck_fall));
    adc_spi_edge_sync u_sdo (.aclk(aclk), .areset(areset), .din(spi.spi_sdo),
                             .q(sdo), .rise(), .fall());

    adc_mode_e                 mode, mode_next;
    logic                      in_reg, active, held;
    logic [5:0]                nedge;
    logic [23:0]               rx;
    logic [ADC_CNV_BITS-1:0]   tx, sample, pattern;
    logic [7:0]                underflow, rd_data;
    logic [6:0]                rd_shift;
    logic [NUM_SDI-1:0]        sdi;
    logic [7:0]                regs [REG_COUNT];
    logic                      frame_ok, is_enter, is_exit, is_write, wr_hit;

    // Frame-end decode; only a frame of exactly 24 rising edges is acted on.
    assign frame_ok = csn_rise && active && (nedge == FRAME_EDGES);
    assign is_enter = frame_ok && (rx[23:21] == ADC_ENTER_PREFIX);
    assign is_exit  = frame_ok && !is_enter && (rx == ADC_EXIT_FRAME);
    assign is_write = frame_ok && !is_enter && !rx[23];
    assign wr_hit   = rx[22:8] < REG_LIMIT;

    always_ff @(posedge aclk) begin
        if (areset) mode <= CNV;
        else        mode <= mode_next;
    end

    always_comb begin
        // NOTE: defaulting every always_comb output first keeps paths that
        // assign nothing from inferring a latch.
        mode_next = mode;
        if (is_enter)     mode_next = REG;
        else if (is_exit) mode_next = CNV;
    end

    always_comb begin
        in_reg        = (mode == REG);
        s_axis_tready = ~held;
        status        = {16'h0, underflow, 4'h0, held, active, mode};
    end

    // After the 16th rise rx[14:0] holds the read address.
    always_comb begin
        rd_data = '0;
        if (rx[14:0] < REG_LIMIT) rd_data = regs[rx[AW-1:0]];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            active    <= 1'b0;
            nedge     <= '0;
            rx        <= '0;
            tx        <= '0;
            rd_shift  <= '0;
            sdi       <= '0;
            held      <= 1'b0;
            sample    <= '0;
            pattern   <= '0;
            underflow <= '0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            // NOTE: the register file has defined power-on contents, so it is
            // cleared here like any other state rather than left to a RAM.
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            reg_wr <= 1'b0;
            if (s_axis_tvalid && !held) begin
                sample <= s_axis_tdata;
                held   <= 1'b1;
            end
            if (csn_rise) begin
                active <= 1'b0;
                sdi    <= '0;
                if (is_write) begin
                    reg_wr    <= 1'b1;
                    reg_addr  <= rx[22:8];
                    reg_wdata <= rx[7:0];
                    if (wr_hit) regs[rx[8 +: AW]] <= rx[7:0];
                end
            end else if (csn_fall) begin
                active   <= 1'b1;
                nedge    <= '0;
                rx       <= '0;
                rd_shift <= '0;
                if (in_reg) begin
                    sdi <= '0;
                end else if (held) begin
                    tx   <= sample;
                    sdi  <= sample[ADC_CNV_BITS-1 -: NUM_SDI];
                    held <= 1'b0;
                end else begin
                    tx      <= pattern;
                    sdi     <= pattern[ADC_CNV_BITS-1 -: NUM_SDI];
                    pattern <= pattern + 1'b1;
                    if (underflow != 8'hFF) underflow <= underflow + 1'b1;
                end
            end else if (active) begin
                if (sck_rise) begin
                    if (nedge < FRAME_EDGES) rx <= {rx[22:0], sdo};
                    if (nedge != 6'd63)      nedge <= nedge + 1'b1;
                end
                if (sck_fall) begin
                    if (!in_reg) begin
                        tx  <= tx << NUM_SDI;
                        sdi <= (tx << NUM_SDI) >> (ADC_CNV_BITS - NUM_SDI);
                    end else if (nedge == 6'd16) begin
                        rd_shift <= rx[15] ? rd_data[6:0] : 7'h0;
                        sdi      <= NUM_SDI'(rx[15] & rd_data[7]);
                    end else if (nedge > 6'd16 && nedge < FRAME_EDGES) begin
                        rd_shift <= {rd_shift[5:0], 1'b0};
                        sdi      <= NUM_SDI'(rd_shift[6]);
                    end else begin
                        sdi <= '0;
                    end
                end
            end
        end
    end

    assign spi.spi_sdi = sdi;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: directed protocol cases followed by
// random traffic, all judged against a frame-level behavioural model.
module tb_adc_spi_responder;
    import adc_pkg::*;

    localparam int NUM_SDI   = 4;
    localparam int REG_COUNT = 16;
    localparam int CHUNKS    = 32 / NUM_SDI;
    localparam int HALF      = 6;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        reg_wr;
    logic [14:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [31:0] status;

    adc_spi_responder_if #(.NUM_SDI(NUM_SDI)) spi ();

    adc_spi_responder #(.NUM_SDI(NUM_SDI), .REG_COUNT(REG_COUNT)) dut (
        .aclk(aclk), .areset(areset), .spi(spi),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .status(status)
    );

    always #5 aclk = ~aclk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-pulse monitor, sampled mid-cycle.
    int          wr_pulses = 0;
    logic [14:0] wr_addr_seen = '0;
    logic [7:0]  wr_data_seen = '0;
    always @(negedge aclk) begin
        if (reg_wr === 1'b1) begin
            wr_pulses++;
            wr_addr_seen = reg_addr;
            wr_data_seen = reg_wdata;
        end
    end

    // Behavioural model state.
    adc_mode_e   m_mode;
    bit          m_held;
    logic [31:0] m_sample;
    logic [31:0] m_pattern;
    int          m_underflow;
    logic [7:0]  m_regs [REG_COUNT];
    int          edge_list [6] = '{1, 10, 16, 23, 25, 30};

    task automatic model_reset();
        m_mode = CNV; m_held = 0; m_sample = 0; m_pattern = 0; m_underflow = 0;
        for (int i = 0; i < REG_COUNT; i++) m_regs[i] = 8'h00;
    endtask

    task automatic model_frame(input int nedges, input logic [23:0] f,
                               output logic [31:0] exp_word, output bit exp_wr,
                               output logic [7:0] exp_rd);
        int a;
        exp_word = 0; exp_wr = 0;
        if (m_mode == CNV) begin
            if (m_held) begin
                exp_word = m_sample; m_held = 0;
            end else begin
                exp_word = m_pattern; m_pattern = m_pattern + 1;
                if (m_underflow < 255) m_underflow++;
            end
        end
        a = int'(f[22:8]);
        exp_rd = (a < REG_COUNT) ? m_regs[a] : 8'h00;
        if (nedges == 24) begin
            if (f[23:21] == ADC_ENTER_PREFIX) begin
                m_mode = REG;
            end else if (!f[23]) begin
                exp_wr = 1;
                if (a < REG_COUNT) m_regs[a] = f[7:0];
                if (f == ADC_EXIT_FRAME) m_mode = CNV;
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Controller side: MOSI MSB first, lanes sampled just as SCK rises.
    task automatic spi_frame(input int nedges, input logic [23:0] f,
                             output logic [31:0] word, output logic [23:0] lane0,
                             output bit upper);
        word = 0; lane0 = 0; upper = 0;
        spi.spi_csn = 1'b0;
        spi.spi_sdo = f[23];
        wait_cycles(8);
        for (int i = 0; i < nedges; i++) begin
            if (i < CHUNKS) word = (word << NUM_SDI) | 32'(spi.spi_sdi);
            if (i < 24)     lane0 = {lane0[22:0], spi.spi_sdi[0]};
            if (|spi.spi_sdi[NUM_SDI-1:1]) upper = 1;
            spi.spi_sck = 1'b1;
            wait_cycles(HALF);
            spi.spi_sck = 1'b0;
            spi.spi_sdo = (i + 1 < 24) ? f[22 - i] : 1'b0;
            wait_cycles(HALF);
        end
        spi.spi_csn = 1'b1;
        spi.spi_sdo = 1'b0;
        wait_cycles(12);
    endtask

    task automatic run_frame(input int nedges, input logic [23:0] f);
        logic [31:0] exp_word, got_word;
        logic [23:0] lane0;
        logic [7:0]  exp_rd;
        bit          upper, exp_wr;
        adc_mode_e   start_mode;
        int          pulses_before;
        start_mode    = m_mode;
        pulses_before = wr_pulses;
        model_frame(nedges, f, exp_word, exp_wr, exp_rd);
        spi_frame(nedges, f, got_word, lane0, upper);
        if (start_mode == CNV) begin
            if (nedges >= CHUNKS) check("cnv_word", got_word, exp_word);
            else check("cnv_word_part", got_word, exp_word >> (32 - nedges * NUM_SDI));
        end else begin
            check("reg_upper_lanes", 32'(upper), 32'd0);
            if (!f[23])
                check("reg_lane0_idle", 32'(lane0), 32'd0);
            else if (nedges == 24 && f[23:21] != ADC_ENTER_PREFIX)
                check("read_lane0", 32'(lane0), {24'h0, exp_rd});
        end
        if (f != ADC_EXIT_FRAME) begin
            check("wr_count", wr_pulses - pulses_before, exp_wr ? 32'd1 : 32'd0);
            if (exp_wr) begin
                check("wr_addr", 32'(wr_addr_seen), 32'(f[22:8]));
                check("wr_data", 32'(wr_data_seen), 32'(f[7:0]));
            end
        end
        check("status", status, {16'h0, 8'(m_underflow), 4'h0, m_held, 1'b0, m_mode});
        check("tready", 32'(s_axis_tready), 32'(!m_held));
    endtask

    task automatic push_sample(input logic [31:0] d);
        check("tready_pre_push", 32'(s_axis_tready), 32'(!m_held));
        if (!m_held) begin
            s_axis_tdata  = d;
            s_axis_tvalid = 1'b1;
            wait_cycles(1);
            s_axis_tvalid = 1'b0;
            m_held = 1; m_sample = d;
            check("tready_post_push", 32'(s_axis_tready), 32'd0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_sdi", 32'(spi.spi_sdi), 32'd0);
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        check("rst_status", status, 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd1);
    endtask

    int          op, pulses_before;
    logic [14:0] ra;
    logic [7:0]  rd;

    initial begin
        areset        = 1'b1;
        spi.spi_csn   = 1'b1;
        spi.spi_sck   = 1'b0;
        spi.spi_sdo   = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        model_reset();
        wait_cycles(5);
        check_reset_outputs();
        areset = 1'b0;
        wait_cycles(5);

        // Queued sample, then two underflow frames.
        push_sample(32'h12345678);
        run_frame(CHUNKS, 24'h0);
        run_frame(CHUNKS, 24'h0);
        run_frame(CHUNKS, 24'h0);

        // Register mode: enter, write, read back, out-of-range read, short frame, exit.
        run_frame(24, 24'hBFFF00);
        run_frame(24, 24'h000A5C);
        run_frame(24, 24'h800A00);
        run_frame(24, 24'hFFFF00);
        run_frame(10, 24'h000A11);
        run_frame(24, ADC_EXIT_FRAME);

        // One-shot register write from conversion mode, verified by readback.
        run_frame(24, 24'h000342);
        run_frame(24, 24'h0010AA);
        run_frame(24, 24'hBFFF00);
        run_frame(24, 24'h800300);
        run_frame(24, 24'h801000);
        run_frame(24, ADC_EXIT_FRAME);

        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 7);
            ra = 15'($urandom_range(0, 19));
            rd = 8'($urandom);
            case (op)
                0:       push_sample($urandom);
                1, 2:    if (m_mode == CNV) run_frame(CHUNKS, 24'($urandom));
                         else run_frame(24, {1'b0, ra, rd});
                3:       run_frame(24, {1'b0, ra, rd});
                4:       run_frame(24, {1'b1, ra, rd});
                5:       run_frame(24, (m_mode == CNV) ? {ADC_ENTER_PREFIX, 21'($urandom)}
                                                       : ADC_EXIT_FRAME);
                6:       run_frame(edge_list[$urandom_range(0, 5)], 24'($urandom));
                default: begin
                    push_sample($urandom);
                    run_frame(CHUNKS, 24'h0);
                end
            endcase
        end

        // Reset in the middle of a frame: 3 rises and 2 falls, then reset.
        pulses_before = wr_pulses;
        spi.spi_csn = 1'b0;
        wait_cycles(8);
        for (int i = 0; i < 3; i++) begin
            spi.spi_sck = 1'b1;
            wait_cycles(HALF);
            if (i < 2) begin
                spi.spi_sck = 1'b0;
                wait_cycles(HALF);
            end
        end
        areset      = 1'b1;
        spi.spi_sck = 1'b0;
        wait_cycles(4);
        check_reset_outputs();
        areset = 1'b0;
        model_reset();
        wait_cycles(6);
        spi.spi_csn = 1'b1;
        wait_cycles(12);
        check("abort_no_write", wr_pulses - pulses_before, 32'd0);
        check("post_reset_status", status, 32'd0);
        run_frame(CHUNKS, 24'h0);
        run_frame(24, 24'h000342);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
